// File: rtl/m_ext_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package m_ext_pkg;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide iteration.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] divisor_i,
  input  logic             bit_i,
  output logic [Width-1:0] rem_o,
  output logic             q_o
);

  logic [Width:0] trial;
  logic [Width:0] diff;

  // Shift in the next dividend bit, subtract if it fits; borrow in the MSB means it did not.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial - {1'b0, divisor_i};
    q_o   = ~diff[Width];
    rem_o = q_o ? diff[Width-1:0] : trial[Width-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
module muldiv_sequencer
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [1:0]      op_q;      // func3[2] is implied by which state we are in
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] dvsr_q, rem_q, quo_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] result_q;
  logic            done_q, busy_q;

  // Capture-cycle decode
  logic            cap_signed, b_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign cap_signed  = ~func3_i[0];
  assign a_mag       = (cap_signed & operand_a_i[XLEN-1]) ? (~operand_a_i + XLEN'(1)) : operand_a_i;
  assign b_mag       = (cap_signed & operand_b_i[XLEN-1]) ? (~operand_b_i + XLEN'(1)) : operand_b_i;
  assign b_zero      = (operand_b_i == '0);
  assign ovf         = cap_signed & (operand_a_i == IntMin) & (operand_b_i == '1);
  assign special     = b_zero | ovf;
  assign special_res = b_zero ? (func3_i[1] ? operand_a_i : '1)
                              : (func3_i[1] ? '0 : IntMin);

  // Multiply: 33-bit extended operands, product taken modulo 2^64
  logic            mul_sa, mul_sb;
  logic [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN-1:0] prod, mul_res_full;
  logic [XLEN-1:0] mul_res;

  assign mul_sa       = (op_q == F3_MULH[1:0]) | (op_q == F3_MULHSU[1:0]);
  assign mul_sb       = (op_q == F3_MULH[1:0]);
  assign a_ext        = {mul_sa & a_q[XLEN-1], a_q};
  assign b_ext        = {mul_sb & b_q[XLEN-1], b_q};
  assign prod         = {{(XLEN-1){a_ext[XLEN]}}, a_ext} * {{(XLEN-1){b_ext[XLEN]}}, b_ext};
  assign mul_res_full = prod;
  assign mul_res      = (op_q == F3_MUL[1:0]) ? mul_res_full[XLEN-1:0]
                                              : mul_res_full[2*XLEN-1:XLEN];

  // Divide datapath
  logic [XLEN-1:0] step_rem, quo_fin, div_res;
  logic            step_q, q_neg, r_neg;

  div_step #(
    .Width (XLEN)
  ) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dvsr_q),
    .bit_i     (quo_q[XLEN-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign quo_fin = {quo_q[XLEN-2:0], step_q};

  // Sign fix-up: quotient negative on sign mismatch, remainder follows the dividend
  always_comb begin
    q_neg   = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg   = ~op_q[0] & a_q[XLEN-1];
    div_res = quo_fin;
    if (op_q[1]) begin
      div_res = r_neg ? (~step_rem + XLEN'(1)) : step_rem;
    end else if (q_neg) begin
      div_res = ~quo_fin + XLEN'(1);
    end
  end

  // Sequencer FSM with registered DONE/BUSY/RESULT
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q   <= func3_i[1:0];
            a_q    <= operand_a_i;
            b_q    <= operand_b_i;
            busy_q <= 1'b1;
            if (!func3_i[2]) begin
              state_q <= StMul;
            end else if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              dvsr_q  <= b_mag;
              quo_q   <= a_mag;
              rem_q   <= '0;
              cnt_q   <= 6'(DIV_ITERS - 1);
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          result_q <= mul_res;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDiv: begin
          rem_q <= step_rem;
          quo_q <= quo_fin;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            result_q <= div_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          // START still belongs to the completing instruction here
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stall_o  = ((state_q == StIdle) & start_i & ~flush_i) |
                    (state_q == StMul) | (state_q == StDiv);
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(
    .XLEN (32)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .func3_i     (func3),
    .operand_a_i (op_a),
    .operand_b_i (op_b),
    .flush_i     (flush),
    .stall_o     (stall),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, hold START until DONE, check latency, stall span and result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    int n;
    int st;
    func3 = f3;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    #1;
    st = stall ? 1 : 0;
    n  = 0;
    do begin
      tick();
      n++;
      if (!done && stall) st++;
    end while (!done && n < 40);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " stall cycles"}, 32'(st), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall in done"}, {31'd0, stall}, 32'd0);
    start = 1'b0;
    tick();
    check({tag, " done drops"}, {31'd0, done}, 32'd0);
    check({tag, " busy drops"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int npulse;
    int p1;
    int p2;
    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    func3   = 3'b000;
    op_a    = '0;
    op_b    = '0;
    tick();
    tick();
    check("reset result", result, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Multiply family: 7 * 0xFFFFFFFD
    run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
    run_op("MULH",   3'b001, 32'd7,        32'hFFFF_FFFD, 2, 32'hFFFF_FFFF);
    run_op("MULHU",  3'b011, 32'd7,        32'hFFFF_FFFD, 2, 32'h0000_0006);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFD, 32'd7,        2, 32'hFFFF_FFFF);

    // Divide family: -20 / 3
    run_op("DIV",  3'b100, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
    run_op("REM",  3'b110, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFE);
    run_op("DIVU", 3'b101, 32'd100,       32'd7, 33, 32'd14);
    run_op("REMU", 3'b111, 32'd20,        32'd3, 33, 32'd2);

    // Flush 10 cycles into a divide; RESULT keeps 2 from REMU
    func3 = 3'b100;
    op_a  = 32'd100;
    op_b  = 32'd7;
    start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("flush busy before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    check("flush stall idle", {31'd0, stall}, 32'd0);
    start = 1'b0;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd2);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) npulse++;
    end
    check("flush no done", 32'(npulse), 32'd0);

    // Special cases
    run_op("DIVU by 0", 3'b101, 32'd5,         32'd0,         1, 32'hFFFF_FFFF);
    run_op("REM by 0",  3'b110, 32'd5,         32'd0,         1, 32'd5);
    run_op("DIV ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("REM ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // Reset in the middle of a divide
    run_op("MUL pre", 3'b000, 32'd6, 32'd7, 2, 32'd42);
    func3 = 3'b100;
    op_a  = 32'd100;
    op_b  = 32'd7;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    check("midrst result", result, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Back-to-back MULs with START held through DONE
    func3  = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd5;
    start  = 1'b1;
    npulse = 0;
    p1     = 0;
    p2     = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (done) begin
        npulse++;
        if (npulse == 1) p1 = n;
        else p2 = n;
        check("b2b result", result, 32'd15);
        if (npulse == 2) start = 1'b0;
      end
    end
    check("b2b pulses", 32'(npulse), 32'd2);
    check("b2b first", 32'(p1), 32'd2);
    check("b2b second", 32'(p2), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
